instr_decoder: RTL and testbench
================================

// Module: instr_decoder
// PURPOSE
//   Sits between the SPI byte bridge and the PWM register file.
//   Turns a framed byte stream (command byte, then data bytes) into single-cycle read/write strobes on the register-file port.
//   Read data is returned to the bridge as a byte to shift out.
//   Supports single accesses and auto-incrementing burst accesses.
// PARAMETERS
//   ADDR_W    6      register address width
//   DATA_W    8      register data width
//   MAX_ADDR  6'h0D  highest legal register address; above it -> error, no access
// PORTS
//   clk         in   1       peripheral clock
//   rst         in   1       synchronous, active-high reset
//   frame       in   1       high for the whole SPI transaction (chip-select active)
//   byte_valid  in   1       1-cycle pulse: data_in holds a complete received byte
//   data_in     in   DATA_W  received byte
//   tx_data     out  DATA_W  byte for the bridge to shift out next
//   tx_load     out  1       1-cycle pulse: tx_data valid
//   read        out  1       1-cycle register read strobe
//   write       out  1       1-cycle register write strobe
//   addr        out  ADDR_W  register address
//   data_write  out  DATA_W  write data to register file
//   data_read   in   DATA_W  combinational read data from register file
//   err         out  1       1-cycle pulse on illegal address / burst overrun
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): every output is 0 and state is S_IDLE. Applies mid-transaction; the partial access is dropped.
//   Command byte: bit7 = 1 write / 0 read; bit6 = 1 burst; bits5:0 = start address.
//   Output registers: all outputs are registered; strobes are high for exactly one cycle.
//   FSM states:
//     S_IDLE: frame=0. Goes to S_CMD when frame=1.
//     S_CMD: waits for the command byte. On byte_valid at cycle T:
//       - addr>MAX_ADDR: err=1 at T+1, go to S_DRAIN.
//       - read: addr=cmd[5:0] and read=1 at T+1. tx_data=data_read (sampled at T+1) and tx_load=1 at T+2. Then S_RD.
//       - write: addr=cmd[5:0] at T+1. Go to S_WR with first=1.
//     S_WR: on byte_valid at T:
//       - first=1: write=1 and data_write=data_in at T+1, at the current addr. Clear first.
//       - first=0 and burst: addr=addr+1, write=1 and data_write=data_in, all at T+1.
//       - non-burst: the second and later data bytes are ignored (S_DRAIN).
//     S_RD, burst: each byte_valid (dummy byte) at T gives addr=addr+1 and read=1 at T+1, and tx_load at T+2.
//     S_RD, non-burst: go to S_DRAIN after the first read.
//     Burst overrun: if addr+1 > MAX_ADDR, no access is made, err=1 at T+1, and addr is held. Go to S_DRAIN; addr never wraps.
//     S_DRAIN: ignores all bytes until frame=0.
//   Frame end: frame=0 in any state -> S_IDLE on the next edge.
//     - Strobes already issued stand.
//     - A command with no data yet is discarded.
//     - byte_valid coincident with frame=0 is dropped; byte_valid while in S_IDLE is ignored.
//   Register holding: addr and data_write hold their last value between accesses. tx_data holds until the next tx_load.
//   Exclusivity: read and write are never high in the same cycle.
// TESTING
//   1 single write: frame=1; bytes 0x8A, 0x05 -> one write pulse, addr=0x0A, data_write=0x05; no tx_load.
//   2 single read: byte 0x03 with data_read=0x34 -> read at T+1 with addr=0x03; tx_load at T+2 with tx_data=0x34; further bytes produce no strobe.
//   3 burst write: 0xC3, 0x11, 0x22, 0x33, 0x44 -> writes (03,11) (04,22) (05,33) (06,44), one cycle each.
//   4 overrun: 0xCC, 0xAA, 0xBB, 0xCC -> writes (0C,AA) (0D,BB); third byte gives err=1, no write, addr stays 0x0D.
//   5 illegal addr: 0x8E, 0x01 -> err pulse, no write. A new frame with 0x81, 0x02 -> write (01,02).
//   6 abort/reset: 0x82 then frame=0, then a new frame with 0x01 -> read of addr 0x01. Also, rst=1 between cmd and data -> no write and all outputs 0.

Source files
------------

// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
//   Sits between the SPI byte bridge and the PWM register file. Turns a
//   framed byte stream (command byte followed by data bytes) into single-cycle
//   read/write strobes on the register-file port. Read data goes back to the
//   bridge as a byte to shift out. Supports single and auto-incrementing
//   burst accesses.
//
//   Command byte: bit7 = 1 write / 0 read, bit6 = 1 burst, bits5:0 = address.
//
// Ports
//   clk_i          peripheral clock
//   rst_i          synchronous, active-high reset
//   frame_i        high for the whole SPI transaction (chip-select active)
//   byte_valid_i   1-cycle pulse: data_in_i holds a complete received byte
//   data_in_i      received byte
//   tx_data_o      byte for the bridge to shift out next
//   tx_load_o      1-cycle pulse: tx_data_o valid
//   read_o         1-cycle register read strobe
//   write_o        1-cycle register write strobe
//   addr_o         register address
//   data_write_o   write data to the register file
//   data_read_i    combinational read data from the register file
//   err_o          1-cycle pulse on illegal address / burst overrun
// ---------------------------------------------------------------------------
module instr_decoder #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 6'h0D
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_i,
    input  logic              byte_valid_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_load_o,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_write_o,
    input  logic [DATA_W-1:0] data_read_i,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WR    = 3'd2,
        S_RD    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q;
    logic              burst_q;
    logic              first_q;
    logic              tx_pend_q;   // a read strobe was issued; load tx_data next cycle
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_write_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_load_q;
    logic              read_q;
    logic              write_q;
    logic              err_q;

    logic [ADDR_W:0]   addr_ext_s;  // one extra bit so the overrun test cannot wrap
    logic [ADDR_W-1:0] addr_inc_s;
    logic              overrun_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic              cmd_bad_s;
    logic              cmd_write_s;
    logic              cmd_burst_s;

    // Command-field decode and next-address / overrun computation.
    always_comb begin
        addr_ext_s  = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
        addr_inc_s  = addr_ext_s[ADDR_W-1:0];
        overrun_s   = (addr_ext_s > {1'b0, MAX_ADDR});
        cmd_addr_s  = data_in_i[ADDR_W-1:0];
        cmd_bad_s   = (cmd_addr_s > MAX_ADDR);
        cmd_write_s = data_in_i[7];
        cmd_burst_s = data_in_i[6];
    end

    // Decoder FSM with registered strobes, address, write data and tx byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            burst_q      <= 1'b0;
            first_q      <= 1'b0;
            tx_pend_q    <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            data_write_q <= {DATA_W{1'b0}};
            tx_data_q    <= {DATA_W{1'b0}};
            tx_load_q    <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Strobes default low so each is high for exactly one cycle.
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            tx_load_q <= 1'b0;
            tx_pend_q <= 1'b0;

            // data_read_i reflects addr_o one cycle after the read strobe
            // was registered; capture it then. Completes even if the frame
            // has just ended, since the read was already issued.
            if (tx_pend_q) begin
                tx_load_q <= 1'b1;
                tx_data_q <= data_read_i;
            end else begin
                tx_data_q <= tx_data_q;
            end

            if (!frame_i) begin
                // Frame end: bytes arriving now are dropped.
                state_q <= S_IDLE;
                first_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Bytes seen in this state are ignored.
                        state_q <= S_CMD;
                    end
                    S_CMD: begin
                        if (byte_valid_i) begin
                            burst_q <= cmd_burst_s;
                            if (cmd_bad_s) begin
                                err_q   <= 1'b1;
                                state_q <= S_DRAIN;
                            end else if (cmd_write_s) begin
                                addr_q  <= cmd_addr_s;
                                first_q <= 1'b1;
                                state_q <= S_WR;
                            end else begin
                                addr_q    <= cmd_addr_s;
                                read_q    <= 1'b1;
                                tx_pend_q <= 1'b1;
                                // A single read needs nothing more from the frame.
                                state_q   <= cmd_burst_s ? S_RD : S_DRAIN;
                            end
                        end else begin
                            state_q <= S_CMD;
                        end
                    end
                    S_WR: begin
                        if (byte_valid_i) begin
                            if (first_q) begin
                                write_q      <= 1'b1;
                                data_write_q <= data_in_i;
                                first_q      <= 1'b0;
                                // Non-burst: later data bytes are ignored.
                                state_q      <= burst_q ? S_WR : S_DRAIN;
                            end else if (overrun_s) begin
                                // Address is held, never wraps.
                                err_q   <= 1'b1;
                                state_q <= S_DRAIN;
                            end else begin
                                addr_q       <= addr_inc_s;
                                write_q      <= 1'b1;
                                data_write_q <= data_in_i;
                            end
                        end else begin
                            state_q <= S_WR;
                        end
                    end
                    S_RD: begin
                        // Each dummy byte triggers the next burst read.
                        if (byte_valid_i) begin
                            if (overrun_s) begin
                                err_q   <= 1'b1;
                                state_q <= S_DRAIN;
                            end else begin
                                addr_q    <= addr_inc_s;
                                read_q    <= 1'b1;
                                tx_pend_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                    S_DRAIN: begin
                        state_q <= S_DRAIN;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_load_o    = tx_load_q;
    assign read_o       = read_q;
    assign write_o      = write_q;
    assign addr_o       = addr_q;
    assign data_write_o = data_write_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_decoder.sv
// ---------------------------------------------------------------------------
// tb_instr_decoder
//   Directed testbench for instr_decoder. A trivial register-file model
//   returns data_read = 0x31 + addr. Inputs are driven and outputs sampled
//   1 time unit after the falling clock edge; a monitor counts strobes on
//   every falling edge so that missing or extra pulses are caught.
// ---------------------------------------------------------------------------
module tb_instr_decoder;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       byte_valid;
    logic [7:0] data_in;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int txl_cnt  = 0;
    int excl_cnt = 0;

    int wr_base;
    int rd_base;
    int err_base;
    int txl_base;

    instr_decoder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .frame_i      (frame),
        .byte_valid_i (byte_valid),
        .data_in_i    (data_in),
        .tx_data_o    (tx_data),
        .tx_load_o    (tx_load),
        .read_o       (read),
        .write_o      (write),
        .addr_o       (addr),
        .data_write_o (data_write),
        .data_read_i  (data_read),
        .err_o        (err)
    );

    // Register-file read model.
    assign data_read = 8'h31 + {2'b00, addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor.
    always @(negedge clk) begin
        if (write)          wr_cnt   = wr_cnt + 1;
        if (read)           rd_cnt   = rd_cnt + 1;
        if (err)            err_cnt  = err_cnt + 1;
        if (tx_load)        txl_cnt  = txl_cnt + 1;
        if (read && write)  excl_cnt = excl_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs === exp_v) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Returns with outputs showing the cycle after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        data_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic snap();
        wr_base  = wr_cnt;
        rd_base  = rd_cnt;
        err_base = err_cnt;
        txl_base = txl_cnt;
    endtask

    task automatic open_frame();
        frame = 1'b1;
        step();
    endtask

    task automatic close_frame();
        frame = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst        = 1'b1;
        frame      = 1'b0;
        byte_valid = 1'b0;
        data_in    = 8'h00;
        step();
        step();
        // Reset state
        check_eq("rst_outs", {tx_load, read, write, err}, 32'h0);
        check_eq("rst_addr", {26'h0, addr}, 32'h0);
        check_eq("rst_data", {16'h0, tx_data, data_write}, 32'h0);
        rst = 1'b0;
        step();

        // 1: single write 0x8A, 0x05
        snap();
        open_frame();
        send_byte(8'h8A);
        check_eq("t1_cmd_addr", {26'h0, addr}, 32'h0A);
        check_eq("t1_cmd_nowr", {31'h0, write}, 32'h0);
        send_byte(8'h05);
        check_eq("t1_wr", {31'h0, write}, 32'h1);
        check_eq("t1_addr", {26'h0, addr}, 32'h0A);
        check_eq("t1_wdata", {24'h0, data_write}, 32'h05);
        send_byte(8'h77);
        step();
        check_eq("t1_wr_cnt", wr_cnt - wr_base, 32'd1);
        check_eq("t1_txl_cnt", txl_cnt - txl_base, 32'd0);
        check_eq("t1_hold", {24'h0, data_write}, 32'h05);
        close_frame();

        // 2: single read 0x03 -> data 0x34
        snap();
        open_frame();
        send_byte(8'h03);
        check_eq("t2_rd", {31'h0, read}, 32'h1);
        check_eq("t2_addr", {26'h0, addr}, 32'h03);
        check_eq("t2_txl_early", {31'h0, tx_load}, 32'h0);
        step();
        check_eq("t2_txl", {31'h0, tx_load}, 32'h1);
        check_eq("t2_txd", {24'h0, tx_data}, 32'h34);
        send_byte(8'h00);
        send_byte(8'h00);
        step();
        check_eq("t2_rd_cnt", rd_cnt - rd_base, 32'd1);
        check_eq("t2_txl_cnt", txl_cnt - txl_base, 32'd1);
        check_eq("t2_txd_hold", {24'h0, tx_data}, 32'h34);
        close_frame();

        // 3: burst write from 0x03
        snap();
        open_frame();
        send_byte(8'hC3);
        send_byte(8'h11);
        check_eq("t3_w0", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h03, 8'h11});
        send_byte(8'h22);
        check_eq("t3_w1", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h04, 8'h22});
        send_byte(8'h33);
        check_eq("t3_w2", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h05, 8'h33});
        send_byte(8'h44);
        check_eq("t3_w3", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h06, 8'h44});
        step();
        check_eq("t3_wr_cnt", wr_cnt - wr_base, 32'd4);
        check_eq("t3_err_cnt", err_cnt - err_base, 32'd0);
        close_frame();

        // 4: burst write overrun at MAX_ADDR
        snap();
        open_frame();
        send_byte(8'hCC);
        send_byte(8'hAA);
        check_eq("t4_w0", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h0C, 8'hAA});
        send_byte(8'hBB);
        check_eq("t4_w1", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h0D, 8'hBB});
        send_byte(8'hCC);
        check_eq("t4_err", {31'h0, err}, 32'h1);
        check_eq("t4_nowr", {31'h0, write}, 32'h0);
        check_eq("t4_addr", {26'h0, addr}, 32'h0D);
        send_byte(8'hDD);
        step();
        check_eq("t4_wr_cnt", wr_cnt - wr_base, 32'd2);
        check_eq("t4_err_cnt", err_cnt - err_base, 32'd1);
        close_frame();

        // 5: illegal address, then a fresh legal frame
        snap();
        open_frame();
        send_byte(8'h8E);
        check_eq("t5_err", {31'h0, err}, 32'h1);
        send_byte(8'h01);
        step();
        check_eq("t5_wr_cnt", wr_cnt - wr_base, 32'd0);
        close_frame();
        open_frame();
        send_byte(8'h81);
        send_byte(8'h02);
        check_eq("t5_w", {31'h0, write, addr, data_write}, {17'h0, 1'b1, 6'h01, 8'h02});
        close_frame();

        // 6a: abort after command, then new frame read of 0x01
        snap();
        open_frame();
        send_byte(8'h82);
        close_frame();
        open_frame();
        send_byte(8'h01);
        check_eq("t6_rd", {31'h0, read, addr}, {25'h0, 1'b1, 6'h01});
        step();
        check_eq("t6_txd", {23'h0, tx_load, tx_data}, {23'h0, 1'b1, 8'h32});
        check_eq("t6_wr_cnt", wr_cnt - wr_base, 32'd0);
        close_frame();

        // 6b: reset between command and data
        snap();
        open_frame();
        send_byte(8'h85);
        rst = 1'b1;
        step();
        check_eq("t6_rst_outs", {tx_load, read, write, err}, 32'h0);
        check_eq("t6_rst_regs", {2'b00, addr, tx_data, data_write}, 32'h0);
        rst = 1'b0;
        send_byte(8'h07);
        step();
        check_eq("t6_rst_wr_cnt", wr_cnt - wr_base, 32'd0);
        check_eq("t6_rst_addr", {26'h0, addr}, 32'h0);
        close_frame();

        // 7: burst read from 0x0C into overrun
        snap();
        open_frame();
        send_byte(8'h4C);
        check_eq("t7_r0", {31'h0, read, addr}, {25'h0, 1'b1, 6'h0C});
        step();
        check_eq("t7_tx0", {23'h0, tx_load, tx_data}, {23'h0, 1'b1, 8'h3D});
        send_byte(8'h00);
        check_eq("t7_r1", {31'h0, read, addr}, {25'h0, 1'b1, 6'h0D});
        step();
        check_eq("t7_tx1", {23'h0, tx_load, tx_data}, {23'h0, 1'b1, 8'h3E});
        send_byte(8'h00);
        check_eq("t7_err", {31'h0, err, read, addr}, {24'h0, 1'b1, 1'b0, 6'h0D});
        step();
        check_eq("t7_rd_cnt", rd_cnt - rd_base, 32'd2);
        check_eq("t7_txl_cnt", txl_cnt - txl_base, 32'd2);
        close_frame();

        check_eq("excl", excl_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
